// File: rtl/csr_file.sv
// Execute-stage CSR file: csrrw/csrrwi writes with registered read-before-write data,
// the tohost exit/status register, and 64-bit cycle/instret counters with clear/freeze control.
module csr_file #(
  parameter logic [11:0] TOHOST_ADDR = 12'h51E,
  parameter logic [11:0] CNTCTL_ADDR = 12'h7C0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        csr_wen,
  input  logic        csr_sel,
  input  logic [11:0] csr_addr,
  input  logic [31:0] rs1_data,
  input  logic [4:0]  zimm,
  input  logic        inst_retire,
  output logic [31:0] csr_rdata,
  output logic [31:0] tohost,
  output logic        tohost_valid
);

  localparam logic [11:0] CYCLE_ADDR    = 12'hC00;
  localparam logic [11:0] CYCLEH_ADDR   = 12'hC80;
  localparam logic [11:0] INSTRET_ADDR  = 12'hC02;
  localparam logic [11:0] INSTRETH_ADDR = 12'hC82;

  logic        we;
  logic [31:0] wdata;
  logic [31:0] rd_val;
  logic [63:0] cycle;
  logic [63:0] instret;
  logic [63:0] cycle_nxt;
  logic [63:0] instret_nxt;
  logic [1:0]  cntctl;
  logic [1:0]  cntctl_nxt;

  always_comb begin
    we    = csr_wen & ~stall;
    wdata = csr_sel ? {27'b0, zimm} : rs1_data;
  end

  always_comb begin
    rd_val = 32'b0;
    case (csr_addr)
      TOHOST_ADDR:   rd_val = tohost;
      CNTCTL_ADDR:   rd_val = {30'b0, cntctl};
      CYCLE_ADDR:    rd_val = cycle[31:0];
      CYCLEH_ADDR:   rd_val = cycle[63:32];
      INSTRET_ADDR:  rd_val = instret[31:0];
      INSTRETH_ADDR: rd_val = instret[63:32];
      default:       rd_val = 32'b0;
    endcase
  end

  // Counter control is sampled from the registered cntctl, so a write to it
  // only affects the counters from the following edge. Clear wins over freeze.
  always_comb begin
    cycle_nxt   = cycle + 64'd1;
    instret_nxt = instret + {63'b0, inst_retire & ~stall};
    if (cntctl[0]) begin
      cycle_nxt   = 64'b0;
      instret_nxt = 64'b0;
    end else if (cntctl[1]) begin
      cycle_nxt   = cycle;
      instret_nxt = instret;
    end
  end

  // Clear bit is a one-cycle pulse unless rewritten on the same edge.
  always_comb begin
    cntctl_nxt = {cntctl[1], 1'b0};
    if (we && (csr_addr == CNTCTL_ADDR)) begin
      cntctl_nxt = wdata[1:0];
    end
  end

  // tohost_valid: high for exactly the one cycle following each accepted
  // tohost write (value change not required); there is no back-pressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csr_rdata    <= 32'b0;
      tohost       <= 32'b0;
      tohost_valid <= 1'b0;
      cycle        <= 64'b0;
      instret      <= 64'b0;
      cntctl       <= 2'b0;
    end else begin
      cycle        <= cycle_nxt;
      instret      <= instret_nxt;
      cntctl       <= cntctl_nxt;
      tohost_valid <= we && (csr_addr == TOHOST_ADDR);
      if (we) begin
        csr_rdata <= rd_val;
        if (csr_addr == TOHOST_ADDR) begin
          tohost <= wdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_csr_file.sv
// Bench for csr_file: directed and random CSR traffic against a behavioural model,
// with expected outputs queued per edge and checked by an independent monitor.
module tb_csr_file;

  localparam logic [11:0] TOHOST = 12'h51E;
  localparam logic [11:0] CNTCTL = 12'h7C0;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        csr_wen;
  logic        csr_sel;
  logic [11:0] csr_addr;
  logic [31:0] rs1_data;
  logic [4:0]  zimm;
  logic        inst_retire;
  logic [31:0] csr_rdata;
  logic [31:0] tohost;
  logic        tohost_valid;

  csr_file #(.TOHOST_ADDR(TOHOST), .CNTCTL_ADDR(CNTCTL)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall        (stall),
    .csr_wen      (csr_wen),
    .csr_sel      (csr_sel),
    .csr_addr     (csr_addr),
    .rs1_data     (rs1_data),
    .zimm         (zimm),
    .inst_retire  (inst_retire),
    .csr_rdata    (csr_rdata),
    .tohost       (tohost),
    .tohost_valid (tohost_valid)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // scoreboard: {tohost_valid, tohost, csr_rdata} expected after each edge
  logic [64:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // reference model state
  logic [63:0] m_cycle;
  logic [63:0] m_instret;
  logic [31:0] m_tohost;
  logic [31:0] m_rdata;
  logic        m_clear;
  logic        m_freeze;

  task automatic model_reset();
    m_cycle   = 64'd0;
    m_instret = 64'd0;
    m_tohost  = 32'd0;
    m_rdata   = 32'd0;
    m_clear   = 1'b0;
    m_freeze  = 1'b0;
  endtask

  function automatic logic [31:0] model_read(input logic [11:0] a);
    case (a)
      TOHOST:  return m_tohost;
      CNTCTL:  return {30'd0, m_freeze, m_clear};
      12'hC00: return m_cycle[31:0];
      12'hC80: return m_cycle[63:32];
      12'hC02: return m_instret[31:0];
      12'hC82: return m_instret[63:32];
      default: return 32'd0;
    endcase
  endfunction

  // Apply the effect of the coming rising edge to the model and queue the outcome.
  task automatic model_edge();
    bit          accepted;
    logic [31:0] wd;
    logic        tv;
    accepted = csr_wen && !stall;
    wd = csr_sel ? {27'd0, zimm} : rs1_data;
    tv = accepted && (csr_addr == TOHOST);
    if (accepted) m_rdata = model_read(csr_addr);
    if (m_clear) begin
      m_cycle   = 0;
      m_instret = 0;
    end else if (!m_freeze) begin
      m_cycle   = m_cycle + 1;
      m_instret = m_instret + ((inst_retire && !stall) ? 1 : 0);
    end
    if (accepted && csr_addr == CNTCTL) begin
      m_clear  = wd[0];
      m_freeze = wd[1];
    end else begin
      m_clear = 1'b0;
    end
    if (tv) m_tohost = wd;
    exp_q.push_back({tv, m_tohost, m_rdata});
  endtask

  // driver tasks: called just after a falling edge, return after the next one
  task automatic step(input bit wen, input bit sel, input logic [11:0] addr,
                      input logic [31:0] rs1, input logic [4:0] z, input bit ret, input bit stl);
    csr_wen     = wen;
    csr_sel     = sel;
    csr_addr    = addr;
    rs1_data    = rs1;
    zimm        = z;
    inst_retire = ret;
    stall       = stl;
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle(input int n, input bit ret);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 12'h000, 32'd0, 5'd0, ret, 1'b0);
  endtask

  task automatic csrrw(input logic [11:0] addr, input logic [31:0] v);
    step(1'b1, 1'b0, addr, v, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic csrrwi(input logic [11:0] addr, input logic [4:0] z);
    step(1'b1, 1'b1, addr, 32'd0, z, 1'b0, 1'b0);
  endtask

  // monitor
  initial begin
    logic [64:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("csr_rdata", {32'd0, csr_rdata}, {32'd0, e[31:0]});
        check("tohost", {32'd0, tohost}, {32'd0, e[63:32]});
        check("tohost_valid", {63'd0, tohost_valid}, {63'd0, e[64]});
      end
    end
  end

  // stimulus
  logic [11:0] addr_tbl [8];

  initial begin
    rst_n = 1'b0;
    stall = 1'b0; csr_wen = 1'b0; csr_sel = 1'b0; csr_addr = 12'h0;
    rs1_data = 32'd0; zimm = 5'd0; inst_retire = 1'b0;
    model_reset();
    addr_tbl = '{TOHOST, CNTCTL, 12'hC00, 12'hC80, 12'hC02, 12'hC82, 12'h123, 12'h000};
    #2;
    check("reset_rdata", {32'd0, csr_rdata}, 64'd0);
    check("reset_tohost", {32'd0, tohost}, 64'd0);
    check("reset_tohost_valid", {63'd0, tohost_valid}, 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // idle, then read cycle count
    idle(10, 1'b0);
    csrrw(12'hC00, 32'd0);

    // tohost writes
    csrrw(TOHOST, 32'h0000_0001);
    csrrwi(TOHOST, 5'd5);
    idle(2, 1'b0);

    // stalled write presented for three cycles
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, TOHOST, 32'h0000_00A5, 5'd0, 1'b1, 1'b1);
    csrrw(TOHOST, 32'h0000_00A5);
    idle(2, 1'b1);

    // instret carry across bit 31 while frozen-then-released
    csrrw(CNTCTL, 32'd2);
    force dut.instret = 64'h0000_0000_FFFF_FFFF;
    idle(1, 1'b1);
    release dut.instret;
    m_instret = 64'h0000_0000_FFFF_FFFF;
    csrrw(CNTCTL, 32'd0);
    idle(1, 1'b1);
    csrrw(12'hC82, 32'd0);
    csrrw(12'hC02, 32'd0);

    // freeze then clear
    csrrw(CNTCTL, 32'd2);
    idle(4, 1'b1);
    csrrw(12'hC02, 32'd0);
    csrrw(12'hC00, 32'd0);
    csrrw(CNTCTL, 32'd1);
    idle(1, 1'b1);
    csrrw(12'hC00, 32'd0);
    csrrw(12'hC02, 32'd0);
    csrrw(CNTCTL, 32'd0);
    idle(3, 1'b1);

    // asynchronous reset mid-cycle with tohost live
    csrrw(TOHOST, 32'h0000_DEAD);
    rst_n = 1'b0;
    #1;
    check("midreset_tohost", {32'd0, tohost}, 64'd0);
    check("midreset_tohost_valid", {63'd0, tohost_valid}, 64'd0);
    check("midreset_rdata", {32'd0, csr_rdata}, 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    idle(2, 1'b0);
    csrrw(12'h123, $urandom);
    idle(1, 1'b0);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic [11:0] a;
      a = addr_tbl[$urandom_range(0, 7)];
      if (a == 12'h000) a = 12'($urandom);
      step(($urandom_range(0, 2) != 0), 1'($urandom), a, $urandom, 5'($urandom),
           1'($urandom), ($urandom_range(0, 4) == 0));
    end
    idle(3, 1'b0);

    check("queue_drain", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
